muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers. It replaces the combinational accumulator path of the ALU for MULT/MULTU/DIV/DIVU/MTHI/MTLO. It sits beside the ALU in the execute stage, and the pipeline stalls on busy. Operand width is a parameter, and results are produced with a fixed multi-cycle latency behind a start/busy/done handshake.

---
 rtl/muldiv_unit.sv | 250 +++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// It sits beside the ALU in the execute stage. The pipeline stalls while
// busy is high.
//
// Operations (op):
//   000 MULT   signed   {hi,lo} = a * b
//   001 MULTU  unsigned {hi,lo} = a * b
//   010 DIV    signed   lo = a / b (truncated toward zero), hi = a % b
//   011 DIVU   unsigned lo = a / b, hi = a % b
//   100 MTHI   hi = a   (single cycle, no busy, no done)
//   101 MTLO   lo = a   (single cycle, no busy, no done)
//   110 MADD   signed   {hi,lo} += a * b   (only with MUL_ACCUM_EN)
//   111 MADDU  unsigned {hi,lo} += a * b   (only with MUL_ACCUM_EN)
//
// Timing: start is sampled at edge N. busy is high for cycles N+1..N+WIDTH+1
// (WIDTH RUN cycles, then one FIX cycle). hi/lo are written on the edge that
// leaves FIX, and done pulses in cycle N+WIDTH+2. A new start is accepted in
// that done cycle. A start seen while busy is ignored.
//
// Optional feature macro: MUL_ACCUM_EN
//   defined   : MADD/MADDU accumulate the product into {hi,lo}
//   undefined : op 110/111 is a no-op and no accumulate adder is built
//
// Ports:
//   clk       system clock, all state on the rising edge
//   reset     synchronous, active-high reset
//   start     operation request, sampled when busy=0
//   op[2:0]   operation select (see table above)
//   a, b      operands (rs, rt), captured at start
//   busy      iterative operation in progress
//   done      one-cycle pulse after HI/LO were written by an iterative op
//   div_zero  sticky flag: the last completed divide had b=0
//   hi, lo    HI/LO registers
// ----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  // State and datapath registers
  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;      // product upper half / partial remainder
  logic [WIDTH-1:0] r_mq;       // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] r_opb;      // |b|, or raw a when dividing by zero
  logic             r_neg_prod; // result (product or quotient) must be negated
  logic             r_neg_rem;  // dividend was negative: remainder is negated
  logic             r_div;
  logic             r_bzero;
  logic             r_done;
  logic             r_dz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
`ifdef MUL_ACCUM_EN
  logic             r_accum;
`endif

  // Operation decode
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_is_mov;
  logic             w_is_iter;
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_bzero;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
`ifdef MUL_ACCUM_EN
  logic             w_is_madd;
`endif

  // Iteration datapath
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_add;

  // Final correction datapath
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_result;
`ifdef MUL_ACCUM_EN
  logic [2*WIDTH-1:0] w_acc_sum;
`endif

  // --------------------------------------------------------------------------
  // Decode and operand magnitudes
  // --------------------------------------------------------------------------
  always_comb begin
    w_is_mul  = (op[2:1] == 2'b00);
    w_is_div  = (op[2:1] == 2'b01);
    w_is_mov  = (op[2:1] == 2'b10);
`ifdef MUL_ACCUM_EN
    w_is_madd = (op[2:1] == 2'b11);
    w_is_iter = w_is_mul | w_is_div | w_is_madd;
`else
    w_is_iter = w_is_mul | w_is_div;
`endif
    w_signed  = ~op[0];
    w_a_neg   = w_signed & a[WIDTH-1];
    w_b_neg   = w_signed & b[WIDTH-1];
    w_a_mag   = w_a_neg ? (~a + 1'b1) : a;
    w_b_mag   = w_b_neg ? (~b + 1'b1) : b;
    w_bzero   = w_is_div & (b == '0);
  end

  // --------------------------------------------------------------------------
  // One iteration step
  // Divide: the partial remainder is always below the divisor, so the shifted
  // value minus the divisor lies in (-2^WIDTH, 2^WIDTH) and bit WIDTH of the
  // difference is the borrow.
  // Multiply: add the multiplicand when the multiplier LSB is set, then shift
  // the {acc, mq} pair right by one with the adder carry entering at the top.
  // --------------------------------------------------------------------------
  always_comb begin
    w_shift  = {r_acc, r_mq[WIDTH-1]};
    w_diff   = w_shift - {1'b0, r_opb};
    w_borrow = w_diff[WIDTH];
    w_sum    = {1'b0, r_acc} + {1'b0, r_opb};
    w_add    = r_mq[0] ? w_sum : {1'b0, r_acc};
  end

  // --------------------------------------------------------------------------
  // Sign correction and HI/LO result selection for the FIX cycle
  // --------------------------------------------------------------------------
  always_comb begin
    w_prod     = {r_acc, r_mq};
    w_prod_fix = r_neg_prod ? (~w_prod + 1'b1) : w_prod;
    w_quo      = r_neg_prod ? (~r_mq + 1'b1) : r_mq;
    w_rem      = r_neg_rem ? (~r_acc + 1'b1) : r_acc;
`ifdef MUL_ACCUM_EN
    w_acc_sum  = {r_hi, r_lo} + w_prod_fix;
`endif
    if (r_div) begin
      // r_opb holds the raw dividend when dividing by zero
      w_result = r_bzero ? {r_opb, {WIDTH{1'b1}}} : {w_rem, w_quo};
    end else begin
`ifdef MUL_ACCUM_EN
      w_result = r_accum ? w_acc_sum : w_prod_fix;
`else
      w_result = w_prod_fix;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM and registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mq       <= '0;
      r_opb      <= '0;
      r_neg_prod <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div      <= 1'b0;
      r_bzero    <= 1'b0;
      r_done     <= 1'b0;
      r_dz       <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
`ifdef MUL_ACCUM_EN
      r_accum    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_is_mov) begin
              if (op[0]) r_lo <= a;
              else       r_hi <= a;
            end else if (w_is_iter) begin
              r_state    <= S_RUN;
              r_cnt      <= CW'(WIDTH - 1);
              r_acc      <= '0;
              r_mq       <= w_a_mag;
              r_opb      <= w_bzero ? a : w_b_mag;
              r_neg_prod <= w_a_neg ^ w_b_neg;
              r_neg_rem  <= w_a_neg;
              r_div      <= w_is_div;
              r_bzero    <= w_bzero;
`ifdef MUL_ACCUM_EN
              r_accum    <= w_is_madd;
`endif
            end
          end
        end

        S_RUN: begin
          // A zero divisor keeps the datapath frozen but still counts, so
          // the latency matches every other iterative op.
          if (!r_bzero) begin
            if (r_div) begin
              r_acc <= w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
              r_mq  <= {r_mq[WIDTH-2:0], ~w_borrow};
            end else begin
              r_acc <= w_add[WIDTH:1];
              r_mq  <= {w_add[0], r_mq[WIDTH-1:1]};
            end
          end
          if (r_cnt == '0) r_state <= S_FIX;
          else             r_cnt   <= r_cnt - 1'b1;
        end

        S_FIX: begin
          {r_hi, r_lo} <= w_result;
          r_done       <= 1'b1;
          if (r_div) r_dz <= r_bzero;
          r_state      <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign div_zero = r_dz;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed bench for muldiv_unit at WIDTH=32. A behavioural model computes
// each result with plain 64-bit arithmetic when the request is accepted, and
// counts down WIDTH+1 cycles before committing it to the expected HI/LO. A
// compare process checks busy/done/div_zero/hi/lo against the model on every
// falling edge. Hand-computed literals after each operation pin the model.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MADDU = 3'b111;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  bit           m_started = 1'b0;
  logic [W-1:0] m_hi, m_lo;
  logic         m_dz, m_done;
  int           m_cnt;
  logic [63:0]  p_res;
  logic         p_div, p_dz, p_madd;

  initial begin
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    m_hi = '0; m_lo = '0; m_dz = 1'b0; m_done = 1'b0; m_cnt = 0;
    p_res = '0; p_div = 1'b0; p_dz = 1'b0; p_madd = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_hi = '0; m_lo = '0; m_dz = 1'b0; m_done = 1'b0; m_cnt = 0;
      end else begin
        m_done = 1'b0;
        if (m_cnt != 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            if (p_madd) {m_hi, m_lo} = {m_hi, m_lo} + p_res;
            else        {m_hi, m_lo} = p_res;
            if (p_div) m_dz = p_dz;
            m_done = 1'b1;
          end
        end else if (start) begin
          sa = {{32{a[31]}}, a};
          sb = {{32{b[31]}}, b};
          ua = {32'b0, a};
          ub = {32'b0, b};
          p_div = 1'b0; p_madd = 1'b0; p_dz = 1'b0;
          case (op)
            OP_MULT:  begin p_res = sa * sb; m_cnt = W + 1; end
            OP_MULTU: begin p_res = ua * ub; m_cnt = W + 1; end
            OP_DIV, OP_DIVU: begin
              p_div = 1'b1;
              m_cnt = W + 1;
              if (b == '0) begin
                p_dz  = 1'b1;
                p_res = {a, 32'hFFFF_FFFF};
              end else if (op == OP_DIV) begin
                q = sa / sb;
                r = sa % sb;
                p_res = {r[31:0], q[31:0]};
              end else begin
                q = ua / ub;
                r = ua % ub;
                p_res = {r[31:0], q[31:0]};
              end
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
`ifdef MUL_ACCUM_EN
            OP_MADD:  begin p_res = sa * sb; p_madd = 1'b1; m_cnt = W + 1; end
            OP_MADDU: begin p_res = ua * ub; p_madd = 1'b1; m_cnt = W + 1; end
`endif
            default: ;
          endcase
        end
      end
      m_started = 1'b1;
    end
  end

  // Compare process: outputs are registered, so sample at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_started) begin
        chk("busy",     {63'b0, busy},     {63'b0, (m_cnt != 0)});
        chk("done",     {63'b0, done},     {63'b0, m_done});
        chk("div_zero", {63'b0, div_zero}, {63'b0, m_dz});
        chk("hi",       {32'b0, hi},       {32'b0, m_hi});
        chk("lo",       {32'b0, lo},       {32'b0, m_lo});
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge)
  // --------------------------------------------------------------------------
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(output int bc);
    int i;
    i  = 0;
    bc = 0;
    while (!done && i < 100) begin
      if (busy) bc++;
      @(negedge clk);
      i++;
    end
    if (!done) chk("done_wait", {63'b0, done}, 64'd1);
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] eh,
                        input logic [W-1:0] el);
    int bc;
    issue(o, x, y);
    wait_done(bc);
    chk({name, "_hi"}, {32'b0, hi}, {32'b0, eh});
    chk({name, "_lo"}, {32'b0, lo}, {32'b0, el});
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    int bc;
    int seen;
    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi",   {32'b0, hi}, 64'd0);
    chk("rst_lo",   {32'b0, lo}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_dz",   {63'b0, div_zero}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // MULT latency and result
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_done(bc);
    chk("mult_busy_cycles", 64'(bc), 64'd33);
    chk("mult_hi", {32'b0, hi}, 64'h0000_0000_FFFF_FFFF);
    chk("mult_lo", {32'b0, lo}, 64'h0000_0000_FFFF_FFFA);

    // Back-to-back: each next start issued in the done cycle
    run_op("multu",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_m7",  OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_7",  OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3);
    run_op("div_nn",  OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3);
    run_op("mult_n1", OP_MULT,  32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9);

    // Divide by zero, then signed overflow clears the flag
    run_op("divu_z",  OP_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF);
    chk("divu_z_flag", {63'b0, div_zero}, 64'd1);
    run_op("div_ovf", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    chk("div_ovf_flag", {63'b0, div_zero}, 64'd0);
    run_op("div_negz", OP_DIV,  32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF);
    chk("div_negz_flag", {63'b0, div_zero}, 64'd1);
    // A multiply leaves the sticky flag alone
    run_op("mult_keep", OP_MULTU, 32'd3,       32'd4,         32'd0,         32'd12);
    chk("mult_keep_flag", {63'b0, div_zero}, 64'd1);

    // MTHI/MTLO on consecutive cycles
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; a = 32'hAAAA_0000;
    @(negedge clk);
    chk("mthi_hi", {32'b0, hi}, 64'h0000_0000_AAAA_0000);
    chk("mthi_lo", {32'b0, lo}, 64'd12);
    op = OP_MTLO; a = 32'h0000_5555;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_hi", {32'b0, hi}, 64'h0000_0000_AAAA_0000);
    chk("mtlo_lo", {32'b0, lo}, 64'h0000_0000_0000_5555);
    chk("mt_busy", {63'b0, busy}, 64'd0);

    // MTHI during busy is dropped
    issue(OP_MULT, 32'd5, 32'd6);
    repeat (5) @(negedge clk);
    start = 1'b1; op = OP_MTHI; a = 32'h0000_DEAD;
    @(negedge clk);
    start = 1'b0;
    chk("mthi_busy_hi", {32'b0, hi}, 64'h0000_0000_AAAA_0000);
    wait_done(bc);
    chk("mult_after_hi", {32'b0, hi}, 64'd0);
    chk("mult_after_lo", {32'b0, lo}, 64'd30);

    // Reset in the middle of a multiply
    issue(OP_MULT, 32'd123, 32'd456);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", {63'b0, busy}, 64'd0);
    chk("midrst_hi",   {32'b0, hi}, 64'd0);
    chk("midrst_lo",   {32'b0, lo}, 64'd0);
    seen = 0;
    repeat (40) begin
      if (done) seen++;
      @(negedge clk);
    end
    chk("midrst_no_done", 64'(seen), 64'd0);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

`ifdef MUL_ACCUM_EN
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; a = 32'd0;
    @(negedge clk);
    op = OP_MTLO; a = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    run_op("maddu", OP_MADDU, 32'd1,         32'd1, 32'd1, 32'd0);
    run_op("madd",  OP_MADD,  32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF);
`else
    // MADD/MADDU are no-ops without the accumulate feature
    issue(OP_MADDU, 32'd1, 32'd1);
    chk("maddu_nop_busy", {63'b0, busy}, 64'd0);
    issue(OP_MADD, 32'hFFFF_FFFF, 32'd1);
    chk("madd_nop_busy", {63'b0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    chk("madd_nop_hi", {32'b0, hi}, 64'd2);
    chk("madd_nop_lo", {32'b0, lo}, 64'd14);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1, "timeout");
  end

endmodule
